// File: rtl/store_queue_if.sv
// store_queue_if: shared types and interfaces for the store queue and its neighbours
package sq_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] data;
  } opt_memory_write_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } cache_output_t;
  typedef enum logic {READ = 1'b0, WRITE = 1'b1} mem_action_t;
endpackage

interface load_forward_ifc;
  logic        addr_valid;
  logic [31:0] addr;
  logic        data_valid;
  logic [31:0] data;
  modport in(input addr_valid, addr, output data_valid, data);
  modport out(output addr_valid, addr, input data_valid, data);
endinterface

interface d_cache_input_ifc;
  import sq_pkg::*;
  logic        valid;
  mem_action_t mem_action;
  logic [31:0] addr;
  logic [31:0] addr_next;
  logic [31:0] data;
  modport out(output valid, mem_action, addr, addr_next, data);
  modport in(input valid, mem_action, addr, addr_next, data);
endinterface

// File: rtl/store_queue.sv
// store_queue: in-order store buffer draining to the D-cache with store-to-load forwarding
module store_queue
  import sq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  opt_memory_write_t i_memory_write,
  output logic              o_wrote,
  load_forward_ifc.in       load_forward,
  d_cache_input_ifc.out     o_request,
  input  cache_output_t     i_response,
  output logic              o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;
  logic [0:0]    state;
  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic          pop;
  logic          unused_rsp_data;
  assign unused_rsp_data = ^i_response.data;
  assign o_wrote = i_memory_write.valid && count < (AW+1)'(DEPTH);
  assign pop = state == BUSY && i_response.valid;
  assign o_empty = count == '0 && state == IDLE;
  assign o_request.valid = state == BUSY;
  assign o_request.mem_action = WRITE;
  assign o_request.addr = addr_q[head];
  assign o_request.addr_next = addr_q[head];
  assign o_request.data = data_q[head];
  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    load_forward.data_valid = 1'b0;
    load_forward.data = '0;
    for (int i = 0; i < DEPTH; i++)
      if (load_forward.addr_valid && (AW+1)'(i) < count && addr_q[head + AW'(i)] == load_forward.addr) begin
        load_forward.data_valid = 1'b1;
        load_forward.data = data_q[head + AW'(i)];
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      state <= IDLE;
    end else begin
      if (o_wrote) begin
        addr_q[tail] <= i_memory_write.addr;
        data_q[tail] <= i_memory_write.data;
        tail <= tail + AW'(1);
      end
      if (pop) head <= head + AW'(1);
      count <= count + (AW+1)'(o_wrote) - (AW+1)'(pop);
      state <= state == IDLE ? (count != '0 ? BUSY : IDLE) : (i_response.valid ? IDLE : BUSY);
    end
  end
endmodule

// File: tb/tb_store_queue.sv
// tb_store_queue: vector table, directed corner sequences and a queue-model random run
module tb_store_queue;
  import sq_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  opt_memory_write_t mw;
  cache_output_t rsp;
  logic wrote, empty;
  load_forward_ifc lf();
  d_cache_input_ifc rq();
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  store_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .i_memory_write(mw), .o_wrote(wrote),
    .load_forward(lf), .o_request(rq), .i_response(rsp), .o_empty(empty)
  );

  typedef struct {
    logic wv; logic [31:0] wa, wd; logic rv, lv; logic [31:0] la;
    logic e_wr, e_rv; logic [31:0] e_ra, e_rd; logic e_em, e_fv; logic [31:0] e_fd;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wv, input logic [31:0] wa, input logic [31:0] wd,
                       input logic rv, input logic lv, input logic [31:0] la);
    mw = '{wv, wa, wd};
    rsp = '{rv, 32'h0};
    lf.addr_valid = lv;
    lf.addr = la;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic wait_req;
    int c = 0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    while (!rq.valid && c < 10) begin
      tick;
      c++;
    end
    chk("wait_req", 32'(c < 10), 1);
  endtask

  task automatic drain;
    int cyc = 0;
    while ((!empty || exp_q.size() != 0) && cyc < 200) begin
      drive(0, 0, 0, rq.valid, 0, 0);
      #1;
      if (rq.valid) chk("drain_addr", rq.addr, exp_q.size() != 0 ? exp_q.pop_front() : 32'hdeadbeef);
      tick;
      cyc++;
    end
    chk("drain_done", 32'(cyc < 200), 1);
  endtask

  task automatic enq_chk(input logic [31:0] a, input logic [31:0] d, input logic e);
    drive(1, a, d, 0, 0, 0);
    #1;
    chk("enq_wrote", wrote, e);
    tick;
  endtask

  initial begin
    int i, cyc, sz;
    logic wv, rv, lv, e_wr, e_fv, nb;
    logic [31:0] wa, wd, la, e_fd;
    logic [31:0] ma[$], md[$];
    bit busy;
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[1]  = '{1, 32'h100, 32'hAA, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0, 0, 1, 32'hAA};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 32'hAA, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 1, 0, 0, 0, 1, 32'h100, 32'hAA, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[6]  = '{1, 32'h200, 32'h11, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    tbl[7]  = '{1, 32'h200, 32'h22, 0, 1, 32'h200, 1, 0, 0, 0, 0, 1, 32'h11};
    tbl[8]  = '{0, 0, 0, 0, 1, 32'h200, 0, 1, 32'h200, 32'h11, 0, 1, 32'h22};
    tbl[9]  = '{0, 0, 0, 0, 1, 32'h204, 0, 1, 32'h200, 32'h11, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 1, 1, 32'h200, 0, 1, 32'h200, 32'h11, 0, 1, 32'h22};
    tbl[11] = '{0, 0, 0, 1, 1, 32'h200, 0, 0, 0, 0, 0, 1, 32'h22};
    tbl[12] = '{0, 0, 0, 1, 0, 0, 0, 1, 32'h200, 32'h22, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    do_reset;
    for (int k = 0; k < 14; k++) begin
      drive(tbl[k].wv, tbl[k].wa, tbl[k].wd, tbl[k].rv, tbl[k].lv, tbl[k].la);
      #1;
      chk($sformatf("v%0d_wrote", k), wrote, tbl[k].e_wr);
      chk($sformatf("v%0d_req_valid", k), rq.valid, tbl[k].e_rv);
      if (tbl[k].e_rv) begin
        chk($sformatf("v%0d_req_addr", k), rq.addr, tbl[k].e_ra);
        chk($sformatf("v%0d_req_next", k), rq.addr_next, tbl[k].e_ra);
        chk($sformatf("v%0d_req_data", k), rq.data, tbl[k].e_rd);
        chk($sformatf("v%0d_req_action", k), rq.mem_action, WRITE);
      end
      chk($sformatf("v%0d_empty", k), empty, tbl[k].e_em);
      chk($sformatf("v%0d_fwd_valid", k), lf.data_valid, tbl[k].e_fv);
      chk($sformatf("v%0d_fwd_data", k), lf.data, tbl[k].e_fd);
      tick;
    end

    // full queue, no bypass while popping
    do_reset;
    for (int k = 0; k < 4; k++) enq_chk(32'h300 + 4 * k, k, 1);
    enq_chk(32'h310, 4, 0);
    drive(1, 32'h310, 4, 1, 0, 0);
    #1;
    chk("full_nobypass", wrote, 0);
    chk("full_head_addr", rq.addr, 32'h300);
    tick;
    enq_chk(32'h310, 4, 1);
    exp_q = {32'h304, 32'h308, 32'h30c, 32'h310};
    drain;

    // wrap with single-cycle responses
    do_reset;
    i = 0;
    cyc = 0;
    while ((i < 10 || !empty) && cyc < 300) begin
      drive(i < 10, 32'(4 * i), 32'h1000 + i, rq.valid, 0, 0);
      #1;
      if (rq.valid) chk("wrap_order", rq.addr, exp_q.size() != 0 ? exp_q.pop_front() : 32'hdeadbeef);
      if (wrote) begin
        exp_q.push_back(32'(4 * i));
        i++;
      end
      tick;
      cyc++;
    end
    chk("wrap_accepted", i, 10);
    chk("wrap_all_drained", exp_q.size(), 0);

    // simultaneous enqueue and pop keeps count
    do_reset;
    enq_chk(32'h400, 1, 1);
    enq_chk(32'h404, 2, 1);
    wait_req;
    drive(1, 32'h408, 3, 1, 0, 0);
    #1;
    chk("simul_wrote", wrote, 1);
    chk("simul_head", rq.addr, 32'h400);
    tick;
    wait_req;
    chk("simul_next", rq.addr, 32'h404);
    enq_chk(32'h40c, 4, 1);
    enq_chk(32'h410, 5, 1);
    enq_chk(32'h414, 6, 0);
    exp_q = {32'h404, 32'h408, 32'h40c, 32'h410};
    drain;

    // reset while busy abandons the write
    do_reset;
    for (int k = 0; k < 3; k++) enq_chk(32'h500 + 4 * k, k, 1);
    wait_req;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    drive(0, 0, 0, 0, 1, 32'h500);
    #1;
    chk("rstbusy_empty", empty, 1);
    chk("rstbusy_req", rq.valid, 0);
    chk("rstbusy_fwd", lf.data_valid, 0);
    tick;
    drive(0, 0, 0, 1, 0, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("late_rsp_empty", empty, 1);
    chk("late_rsp_req", rq.valid, 0);
    enq_chk(32'h600, 7, 1);
    exp_q = {32'h600};
    drain;

    // random run against a queue model
    do_reset;
    busy = 0;
    for (int c = 0; c < 2000; c++) begin
      wv = $urandom_range(0, 2) != 0;
      wa = 32'h700 + 4 * $urandom_range(0, 3);
      wd = $urandom;
      rv = $urandom_range(0, 3) == 0;
      lv = $urandom_range(0, 1);
      la = 32'h700 + 4 * $urandom_range(0, 4);
      drive(wv, wa, wd, rv, lv, la);
      #1;
      sz = ma.size();
      e_wr = wv && sz < 4;
      e_fv = 0;
      e_fd = 0;
      for (int j = sz - 1; j >= 0; j--)
        if (lv && !e_fv && ma[j] == la) begin
          e_fv = 1;
          e_fd = md[j];
        end
      chk("rnd_wrote", wrote, e_wr);
      chk("rnd_req_valid", rq.valid, busy);
      if (busy) begin
        chk("rnd_req_addr", rq.addr, ma[0]);
        chk("rnd_req_data", rq.data, md[0]);
      end
      chk("rnd_empty", empty, sz == 0 && !busy);
      chk("rnd_fwd_valid", lf.data_valid, e_fv);
      chk("rnd_fwd_data", lf.data, e_fd);
      nb = busy ? !rv : sz > 0;
      if (busy && rv) begin
        void'(ma.pop_front());
        void'(md.pop_front());
      end
      if (e_wr) begin
        ma.push_back(wa);
        md.push_back(wd);
      end
      busy = nb;
      tick;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
